// File: rtl/fifo_uart_tx_drain_pkg.sv
// Shared types and constants for the FIFO-draining UART transmitter.
package fifo_uart_tx_drain_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT_DV = 3'd1,
    ST_START   = 3'd2,
    ST_DATA    = 3'd3,
    ST_STOP    = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  localparam logic UART_START_LVL = 1'b0;
  localparam logic UART_STOP_LVL  = 1'b1;
  localparam logic UART_IDLE_LVL  = 1'b1;
  localparam int   DATA_BITS      = 8;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/fifo_uart_tx_drain_timer.sv
// Loadable down-counter; o_Expire is high while the count sits at zero.
module uart_bit_timer
  import fifo_uart_tx_drain_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         i_Clk,
  input  logic         i_Rst,
  input  logic         i_Load,
  input  logic [W-1:0] i_Load_Val,
  output logic         o_Expire
);

  logic [W-1:0] r_Count;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_Count <= '0;
    end else if (i_Load) begin
      r_Count <= i_Load_Val;
    end else if (r_Count != '0) begin
      r_Count <= r_Count - 1'b1;
    end
  end

  assign o_Expire = (r_Count == '0);

endmodule

// File: rtl/fifo_uart_tx_drain.sv
// Pops bytes from a synchronous FIFO one at a time and sends each as an
// 8N1 (or 8N2) UART frame, LSB first.
module fifo_uart_tx_drain
  import fifo_uart_tx_drain_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217,
  parameter int STOP_BITS    = 1,
  parameter int RD_TIMEOUT   = 4
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        i_Enable,
  input  logic        i_Empty,
  output logic        o_Rd_En,
  input  logic        i_Rd_DV,
  input  logic [7:0]  i_Rd_Data,
  output logic        o_Tx_Serial,
  output logic        o_Busy,
  output logic        o_Tx_Done,
  output logic        o_Rd_Err,
  output logic [15:0] o_Tx_Count,
  output logic [2:0]  o_Dbg_State
);

  // One timer serves both bit timing and the read timeout, so it is sized for the larger.
  localparam int TMR_W = max_int($clog2(STOP_BITS * CLKS_PER_BIT), $clog2(RD_TIMEOUT));
  localparam logic [TMR_W-1:0] BIT_LOAD  = TMR_W'(CLKS_PER_BIT - 1);
  localparam logic [TMR_W-1:0] STOP_LOAD = TMR_W'(STOP_BITS * CLKS_PER_BIT - 1);
  localparam logic [TMR_W-1:0] TMO_LOAD  = TMR_W'(RD_TIMEOUT - 1);
  localparam logic [2:0]       LAST_BIT  = 3'(DATA_BITS - 1);

  state_t             r_State;
  state_t             w_Next;
  logic               w_Fetch;
  logic               w_Load;
  logic [TMR_W-1:0]   w_Load_Val;
  logic               w_Expire;
  logic               w_Tx_Next;
  logic [7:0]         r_Shift;
  logic [2:0]         r_Bit_Idx;
  logic               r_Rd_En;
  logic               r_Rd_Err;
  logic               r_Tx;
  logic [15:0]        r_Tx_Count;

  // Read handshake: o_Rd_En pulses for one clock to pop; the FIFO answers with
  // i_Rd_DV and i_Rd_Data some clocks later, and only the first DV seen in
  // WAIT_DV is accepted. No new pop is issued until the frame has finished.
  assign w_Fetch = (r_State == ST_IDLE) && i_Enable && !i_Empty;

  uart_bit_timer #(.W(TMR_W)) u_timer (
    .i_Clk      (i_Clk),
    .i_Rst      (i_Rst),
    .i_Load     (w_Load),
    .i_Load_Val (w_Load_Val),
    .o_Expire   (w_Expire)
  );

  always_ff @(posedge i_Clk) begin
    if (i_Rst) r_State <= ST_IDLE;
    else       r_State <= w_Next;
  end

  always_comb begin
    w_Next = r_State;
    case (r_State)
      ST_IDLE:    if (w_Fetch) w_Next = ST_WAIT_DV;
      ST_WAIT_DV: begin
        if (i_Rd_DV)       w_Next = ST_START;
        else if (w_Expire) w_Next = ST_IDLE;
      end
      ST_START:   if (w_Expire) w_Next = ST_DATA;
      ST_DATA:    if (w_Expire && (r_Bit_Idx == LAST_BIT)) w_Next = ST_STOP;
      ST_STOP:    if (w_Expire) w_Next = ST_DONE;
      ST_DONE:    w_Next = ST_IDLE;
      default:    w_Next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_Load     = 1'b0;
    w_Load_Val = BIT_LOAD;
    case (r_State)
      ST_IDLE: if (w_Fetch) begin
        w_Load     = 1'b1;
        w_Load_Val = TMO_LOAD;
      end
      ST_WAIT_DV: if (i_Rd_DV) w_Load = 1'b1;
      ST_START:   if (w_Expire) w_Load = 1'b1;
      ST_DATA: if (w_Expire) begin
        w_Load     = 1'b1;
        w_Load_Val = (r_Bit_Idx == LAST_BIT) ? STOP_LOAD : BIT_LOAD;
      end
      default: w_Load = 1'b0;
    endcase

    // Line level for the coming state; a DATA->DATA step shows the next shifted bit.
    case (w_Next)
      ST_START: w_Tx_Next = UART_START_LVL;
      ST_DATA:  w_Tx_Next = ((r_State == ST_DATA) && w_Expire) ? r_Shift[1] : r_Shift[0];
      ST_STOP,
      ST_DONE:  w_Tx_Next = UART_STOP_LVL;
      default:  w_Tx_Next = UART_IDLE_LVL;
    endcase

    o_Busy      = (r_State != ST_IDLE);
    o_Tx_Done   = (r_State == ST_DONE);
    o_Dbg_State = r_State;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_Shift    <= '0;
      r_Bit_Idx  <= '0;
      r_Rd_En    <= 1'b0;
      r_Rd_Err   <= 1'b0;
      r_Tx       <= UART_IDLE_LVL;
      r_Tx_Count <= '0;
    end else begin
      r_Rd_En  <= w_Fetch;
      r_Rd_Err <= (r_State == ST_WAIT_DV) && !i_Rd_DV && w_Expire;
      r_Tx     <= w_Tx_Next;
      if ((r_State == ST_WAIT_DV) && i_Rd_DV) begin
        r_Shift   <= i_Rd_Data;
        r_Bit_Idx <= '0;
      end else if ((r_State == ST_DATA) && w_Expire) begin
        r_Shift   <= {1'b0, r_Shift[7:1]};
        r_Bit_Idx <= r_Bit_Idx + 3'd1;
      end
      if ((r_State == ST_STOP) && w_Expire) r_Tx_Count <= r_Tx_Count + 16'd1;
    end
  end

  assign o_Rd_En     = r_Rd_En;
  assign o_Rd_Err    = r_Rd_Err;
  assign o_Tx_Serial = r_Tx;
  assign o_Tx_Count  = r_Tx_Count;

endmodule

// File: tb/tb_fifo_uart_tx_drain.sv
// Bench for fifo_uart_tx_drain: FIFO responder, frame-level reference model,
// per-cycle compare, UART decoder and directed scenarios.
module tb_fifo_uart_tx_drain;

  localparam int CPB   = 4;
  localparam int STOPB = 1;
  localparam int RDTO  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        empty = 1'b1;
  logic        dv = 1'b0;
  logic [7:0]  rd_data = 8'h00;
  logic        o_Rd_En, o_Tx_Serial, o_Busy, o_Tx_Done, o_Rd_Err;
  logic [15:0] o_Tx_Count;
  logic [2:0]  dbg_state;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  fifo_uart_tx_drain #(.CLKS_PER_BIT(CPB), .STOP_BITS(STOPB), .RD_TIMEOUT(RDTO)) dut (
    .i_Clk(clk), .i_Rst(rst), .i_Enable(en), .i_Empty(empty), .o_Rd_En(o_Rd_En),
    .i_Rd_DV(dv), .i_Rd_Data(rd_data), .o_Tx_Serial(o_Tx_Serial), .o_Busy(o_Busy),
    .o_Tx_Done(o_Tx_Done), .o_Rd_Err(o_Rd_Err), .o_Tx_Count(o_Tx_Count),
    .o_Dbg_State(dbg_state)
  );

  // FIFO responder: one clock of read latency; stub mode claims data but never answers.
  logic [7:0] fifo_mem [0:15];
  int wr_ptr = 0;
  int rd_ptr = 0;
  bit stub_no_dv = 1'b0;

  always @(posedge clk) begin
    if (stub_no_dv) begin
      dv    <= 1'b0;
      empty <= 1'b0;
    end else if (o_Rd_En && (rd_ptr != wr_ptr)) begin
      rd_data <= fifo_mem[rd_ptr % 16];
      dv      <= 1'b1;
      rd_ptr  <= rd_ptr + 1;
      empty   <= ((rd_ptr + 1) == wr_ptr);
    end else begin
      dv    <= 1'b0;
      empty <= (rd_ptr == wr_ptr);
    end
  end

  // Reference model: frame waveform generated from the byte once it is accepted.
  logic [1:0]  wave_q [$];
  bit          model_valid = 1'b0;
  int          phase = 0;
  int          wait_n = 0;
  logic        e_line = 1'b1, e_rd_en = 1'b0, e_busy = 1'b0, e_done = 1'b0, e_err = 1'b0;
  logic [15:0] e_cnt = 16'd0;

  function automatic void build_frame(input logic [7:0] b);
    for (int i = 0; i < CPB; i++) wave_q.push_back(2'b00);
    for (int k = 0; k < 8; k++)
      for (int i = 0; i < CPB; i++) wave_q.push_back({1'b0, b[k]});
    for (int i = 0; i < STOPB * CPB; i++) wave_q.push_back(2'b01);
    wave_q.push_back(2'b11);
  endfunction

  function automatic void pop_wave();
    logic [1:0] w;
    w      = wave_q.pop_front();
    e_line = w[0];
    e_busy = 1'b1;
    if (w[1]) begin
      e_done = 1'b1;
      e_cnt  = e_cnt + 16'd1;
    end
  endfunction

  initial forever begin
    @(posedge clk);
    e_rd_en = 1'b0; e_done = 1'b0; e_err = 1'b0; e_line = 1'b1; e_busy = 1'b0;
    if (rst) begin
      model_valid = 1'b1;
      phase = 0;
      wave_q.delete();
      e_cnt = 16'd0;
    end else if (model_valid) begin
      case (phase)
        0: if (en && !empty) begin
          e_rd_en = 1'b1; e_busy = 1'b1; phase = 1; wait_n = 0;
        end
        1: begin
          wait_n++;
          if (dv) begin
            build_frame(rd_data);
            pop_wave();
            phase = 2;
          end else if (wait_n == RDTO) begin
            e_err = 1'b1; phase = 0;
          end else begin
            e_busy = 1'b1;
          end
        end
        default: if (wave_q.size() == 0) phase = 0; else pop_wave();
      endcase
    end
  end

  // Per-cycle compare of every output against the model.
  initial forever begin
    @(negedge clk);
    if (model_valid) begin
      tests++;
      if ({o_Tx_Serial, o_Rd_En, o_Busy, o_Tx_Done, o_Rd_Err, o_Tx_Count} !==
          {e_line, e_rd_en, e_busy, e_done, e_err, e_cnt}) begin
        fails++;
        $display("FAIL cycle_outputs @%0d: got line=%b rd_en=%b busy=%b done=%b err=%b cnt=%0d, want %b %b %b %b %b %0d",
                 cyc, o_Tx_Serial, o_Rd_En, o_Busy, o_Tx_Done, o_Rd_Err, o_Tx_Count,
                 e_line, e_rd_en, e_busy, e_done, e_err, e_cnt);
      end
    end
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Event monitors and UART decoder; all counters clear while reset is held.
  int rd_cnt = 0, done_cnt = 0, err_cnt = 0, rx_starts = 0;
  int last_rd = 0, last_err = 0, min_gap = 1000000;
  logic [7:0] rx_q [$];
  logic [7:0] rx_b = 8'h00;
  bit rx_on = 1'b0;
  int rx_n = 0;
  logic prev_line = 1'b1;

  initial forever begin
    @(negedge clk);
    if (rst) begin
      rx_q.delete();
      rx_on = 1'b0; rd_cnt = 0; done_cnt = 0; err_cnt = 0; rx_starts = 0;
      min_gap = 1000000;
    end else begin
      if (o_Rd_En) begin
        if (rd_cnt > 0 && (cyc - last_rd) < min_gap) min_gap = cyc - last_rd;
        last_rd = cyc;
        rd_cnt++;
      end
      if (o_Tx_Done) done_cnt++;
      if (o_Rd_Err) begin
        err_cnt++;
        last_err = cyc;
      end
      if (!rx_on && prev_line && !o_Tx_Serial) begin
        rx_on = 1'b1; rx_n = 0; rx_starts++;
      end else if (rx_on) begin
        rx_n++;
        if (rx_n >= CPB + CPB / 2 && ((rx_n - CPB / 2) % CPB) == 0) begin
          if ((rx_n - CPB / 2) / CPB - 1 < 8) begin
            rx_b[(rx_n - CPB / 2) / CPB - 1] = o_Tx_Serial;
          end else begin
            rx_q.push_back(rx_b);
            rx_on = 1'b0;
          end
        end
      end
    end
    prev_line = o_Tx_Serial;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input int n);
    rst = 1'b1;
    tick(n);
    rst = 1'b0;
  endtask

  task automatic push(input logic [7:0] b);
    fifo_mem[wr_ptr % 16] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic wait_done(input int target, input int budget);
    int k = 0;
    while (done_cnt < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("done_count", done_cnt, target);
  endtask

  task automatic wait_line_low(input int budget);
    int k = 0;
    @(negedge clk);
    while (o_Tx_Serial !== 1'b0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("start_bit_seen", o_Tx_Serial, 0);
  endtask

  logic [39:0] cap;
  int first_rd, first_err;

  initial begin
    #1;
    // Reset with a byte waiting and enable high: nothing may be fetched.
    push(8'hAB);
    en = 1'b1;
    tick(4);
    @(negedge clk);
    check("rst_line", o_Tx_Serial, 1);
    check("rst_rd_en", o_Rd_En, 0);
    check("rst_busy", o_Busy, 0);
    check("rst_count", o_Tx_Count, 0);
    check("rst_state", dbg_state, 0);
    check("rst_fifo_not_empty", empty, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single byte 0xAB, checked sample by sample.
    wait_line_low(20);
    for (int i = 0; i < 40; i++) begin
      cap[i] = o_Tx_Serial;
      if (i < 39) @(negedge clk);
    end
    check("frame_AB_wave", cap, 40'hFF0F0F0FF0);
    wait_done(1, 50);
    tick(6);
    check("ab_rd_pulses", rd_cnt, 1);
    check("ab_tx_count", o_Tx_Count, 1);
    check("ab_fifo_empty", empty, 1);
    check("ab_rx_n", rx_q.size(), 1);
    if (rx_q.size() > 0) check("ab_rx_byte", rx_q[0], 8'hAB);

    // Four queued bytes, back to back.
    apply_reset(2);
    for (int i = 0; i < 4; i++) push(8'h30 + 8'(i));
    wait_done(4, 400);
    tick(5);
    check("burst_rd_pulses", rd_cnt, 4);
    check("burst_gap_ge40", (min_gap >= 40), 1);
    check("burst_tx_count", o_Tx_Count, 4);
    check("burst_rx_n", rx_q.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < rx_q.size()) check("burst_rx_byte", rx_q[i], 8'h30 + 8'(i));

    // FIFO that never answers: timeout, then immediate refetch.
    stub_no_dv = 1'b1;
    apply_reset(2);
    begin
      int k = 0;
      while (err_cnt < 1 && k < 40) begin @(negedge clk); k++; end
    end
    check("tmo_err_seen", err_cnt, 1);
    first_rd  = last_rd;
    first_err = last_err;
    check("tmo_err_delay", first_err - first_rd, 4);
    begin
      int k = 0;
      while (rd_cnt < 2 && k < 10) begin @(negedge clk); k++; end
    end
    check("tmo_refetch_delay", last_rd - first_err, 1);
    check("tmo_no_start_bit", rx_starts, 0);
    @(posedge clk); #1;
    en = 1'b0;
    stub_no_dv = 1'b0;
    tick(10);

    // Enable dropped mid-frame with bytes still queued.
    apply_reset(2);
    push(8'h55); push(8'h66); push(8'h77);
    en = 1'b1;
    wait_line_low(20);
    tick(8);
    en = 1'b0;
    wait_done(1, 100);
    tick(60);
    check("endrop_rd_pulses", rd_cnt, 1);
    check("endrop_tx_count", o_Tx_Count, 1);
    check("endrop_fifo_not_empty", empty, 0);
    check("endrop_rx_n", rx_q.size(), 1);
    if (rx_q.size() > 0) check("endrop_rx_byte", rx_q[0], 8'h55);

    // Reset pulse during data bit 3 of 0x66; 0x77 must follow intact.
    apply_reset(1);
    en = 1'b1;
    wait_line_low(20);
    repeat (17) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_line", o_Tx_Serial, 1);
    check("midrst_busy", o_Busy, 0);
    check("midrst_count", o_Tx_Count, 0);
    wait_done(1, 100);
    tick(4);
    check("midrst_tx_count", o_Tx_Count, 1);
    check("midrst_rx_n", rx_q.size(), 1);
    if (rx_q.size() > 0) check("midrst_rx_byte", rx_q[0], 8'h77);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #300000;
    fails++;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
